// File: rtl/uart_report_tx_if.sv
// uart_report_tx_if: controller/buffer/line bundle (send, uartsel, rd_addr, rd_data, tx, busy, done)
interface uart_report_tx_if #(parameter int IDX_W = 4);
  logic send;
  logic [2:0] uartsel;
  logic [2+IDX_W:0] rd_addr;
  logic [7:0] rd_data;
  logic tx;
  logic busy;
  logic done;
  modport master(output send, uartsel, rd_data, input rd_addr, tx, busy, done);
  modport slave(input send, uartsel, rd_data, output rd_addr, tx, busy, done);
endinterface

// File: rtl/uart_report_tx.sv
// uart_report_tx: 8N1 report serializer; clk, async reset, bus: send/uartsel in, rd_addr/rd_data buffer port, tx/busy/done out
module uart_report_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int NBYTES = 4,
  parameter int IDX_W = 4
) (
  input logic clk,
  input logic reset,
  uart_report_tx_if.slave bus
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  typedef enum logic [2:0] {IDLE, LOAD0, LOAD1, START, DATA, STOP, FIN} state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [2:0] bitn;
  logic [7:0] sh, chk, hdr;
  logic [2:0] sel_q;
  logic [IDX_W:0] idx;
  logic chk_sent, tick, timing;
  assign hdr = {5'b10100, bus.uartsel};
  assign tick = cnt == CW'(CLKS_PER_BIT - 1);
  assign timing = state == START || state == DATA || state == STOP;
  assign bus.tx = state == START ? 1'b0 : state == DATA ? sh[0] : 1'b1;
  assign bus.busy = !(state == IDLE || state == FIN);
  assign bus.done = state == FIN;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = bus.send ? START : IDLE;
      LOAD0: nxt = LOAD1;
      LOAD1: nxt = START;
      START: nxt = tick ? DATA : START;
      DATA: nxt = tick && bitn == 3'd7 ? STOP : DATA;
      STOP: nxt = !tick ? STOP : chk_sent ? FIN : idx < (IDX_W+1)'(NBYTES) ? LOAD0 : START;
      FIN: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt <= '0;
      bitn <= '0;
      sh <= '0;
      chk <= '0;
      sel_q <= '0;
      idx <= '0;
      chk_sent <= 1'b0;
      bus.rd_addr <= '0;
    end else begin
      cnt <= timing && !tick ? cnt + 1'b1 : '0;
      if (state == DATA && tick) begin
        bitn <= bitn + 1'b1;
        sh <= sh >> 1;
      end
      if (state == IDLE && bus.send) begin
        sel_q <= bus.uartsel;
        sh <= hdr;
        chk <= hdr;
        chk_sent <= 1'b0;
      end
      if (nxt == LOAD0) bus.rd_addr <= {sel_q, idx[IDX_W-1:0]};
      if (state == LOAD1) begin
        sh <= bus.rd_data;
        chk <= chk ^ bus.rd_data;
        idx <= idx + 1'b1;
      end
      // STOP straight into START only happens after the last payload byte
      if (state == STOP && nxt == START) begin
        sh <= chk;
        chk_sent <= 1'b1;
      end
      if (state == FIN) idx <= '0;
    end
endmodule

// File: doc/uart_report_tx.md
# uart_report_tx

Serializes one status report over an 8N1 UART line each time the top-level controller selects a report source and starts a transmit phase. Sits directly downstream of the controller: it consumes the controller's `uartsel` code and start pulse and drives the physical `tx` pin. The report frame is a header byte, NBYTES payload bytes read from an external synchronous buffer bank, and an XOR checksum. `done` tells the controller the line is free again.

## Interface
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); legal range ≥ 2.
- NBYTES, 4, payload bytes per report; legal range 1..16.
- IDX_W, 4, payload index width; must satisfy 2^IDX_W ≥ NBYTES.

- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- send  in  1  start request, sampled only in IDLE.
- uartsel  in  3  report source code, latched on accepted `send`.
- rd_addr  out  3+IDX_W  buffer read address {sel_q, idx}.
- rd_data  in  8  buffer data, valid one cycle after `rd_addr`.
- tx  out  1  UART line, idle high.
- busy  out  1  high from the cycle after `send` is accepted through the final stop bit.
- done  out  1  single-cycle pulse on frame completion.

## Operation
- Reset values: tx=1, busy=0, done=0, rd_addr=0, sel_q=0, idx=0, chk=0, state=IDLE.
- States: IDLE, LOAD0, LOAD1, START, DATA, STOP, FIN.
- IDLE: on send=1, latch sel_q=uartsel; load shift reg with header {5'b10100, uartsel}; set chk=header; go to START. send is ignored in every other state.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: 8 bits LSB first, each held CLKS_PER_BIT cycles.
- STOP: tx=1 for CLKS_PER_BIT cycles. Then:
  - Header or payload byte just sent and idx<NBYTES: go to LOAD0.
  - Last payload byte just sent: load shift reg with chk, go to START.
  - Checksum just sent: go to FIN.
- LOAD0: drive rd_addr={sel_q, idx}; go to LOAD1.
- LOAD1: capture rd_data into shift reg; chk ^= rd_data; idx++; go to START.
- FIN: done=1, busy=0, idx=0; go to IDLE.
- Byte order on the line: header, payload[0..NBYTES-1], checksum. Checksum = header XOR all payload bytes.
- Bit timer counts 0..CLKS_PER_BIT-1 with width $clog2(CLKS_PER_BIT); it wraps to 0 at every bit boundary.
- rd_addr holds its last value outside LOAD0.

## Timing
- send accepted at edge E: busy=1 and tx=0 (header start bit) from edge E+1.
- Each byte occupies 10·CLKS_PER_BIT cycles. Each payload byte is preceded by 2 LOAD cycles with tx=1.
- busy high for exactly (NBYTES+2)·10·CLKS_PER_BIT + 2·NBYTES cycles.
- done pulses in the first cycle busy is low, i.e. in FIN.
- send held high continuously: the next frame is accepted on the edge leaving FIN→IDLE+1. There is exactly one FIN cycle plus one IDLE cycle between frames, with tx=1.
- Reset asserted mid-frame: tx=1, busy=0 immediately (asynchronous). No done pulse. The partial frame is abandoned. The next accepted send starts a fresh frame.
- Simultaneous reset and send: reset wins; send is not latched.
- uartsel changing while busy: no effect (sel_q is used).

## Test plan
- Reset: assert reset mid-DATA -> tx=1, busy=0, done=0, rd_addr=0 without waiting for a clock edge.
- Basic frame (CLKS_PER_BIT=4, NBYTES=4, uartsel=3, buffer 0x11,0x22,0x44,0x88):
  - Bytes decoded on tx: 0xA3, 0x11, 0x22, 0x44, 0x88, 0x5C.
  - busy high 248 cycles; one done pulse.
  - rd_addr sequence 0x30..0x33.
- Ignored send: pulse send 50 cycles into a frame with uartsel=5 -> frame unchanged; header remains 0xA3; no second frame follows.
- Back-to-back: hold send=1 with uartsel=0, buffer all 0x00 -> two frames 0xA0,0x00×4,0xA0, separated by exactly 2 idle-high cycles; two done pulses.
- Reset abort: reset for 1 cycle during payload byte 2, then send with uartsel=1 -> clean frame starting with header 0xA1; checksum excludes any pre-reset data.
- Bit timing: CLKS_PER_BIT=434 -> each tx bit lasts exactly 434 cycles; start-bit falling edge occurs exactly 1 cycle after send is sampled.
